tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//   Time-division demultiplexer: the receive end of the serial channel-select path.
//   Takes one serial bitstream (MSB-first slots, frame-aligned by a sync strobe) and
//   distributes slot k to parallel channel output k, registered per frame.
//   Sits after the line interface; feeds per-channel consumers with a frame-valid pulse.
// PARAMETERS
//   NUM_CH   4   number of channels (slots) per frame, >=2
//   SLOT_W   8   bits per slot, >=2
// PORTS
//   clk          in   1              single clock, rising edge
//   rst_n        in   1              synchronous, active-low reset
//   din          in   1              serial data bit
//   din_en       in   1              din qualifies this cycle; all other inputs ignored when 0
//   sync         in   1              frame start; valid only with din_en, marks slot0 bit MSB
//   ch_data      out  NUM_CH*SLOT_W  channel k at [k*SLOT_W +: SLOT_W]; held between frames
//   frame_valid  out  1              one-cycle pulse: ch_data updated with a complete frame
//   sync_err     out  1              one-cycle pulse: sync protocol violation detected
//   locked       out  1              1 while in RUN state
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): ch_data=0, frame_valid=0, sync_err=0, locked=0,
//     state=HUNT, bit/slot counters=0, shift reg=0, frame shadow=0. Mid-frame reset
//     discards partial data; no frame_valid for it.
//   States: HUNT, RUN.
//   HUNT: bits without sync dropped silently. din_en&sync -> bit is slot0 MSB,
//     go RUN (bit_cnt=1, slot_cnt=0).
//   RUN: each din_en shifts din in MSB-first. At bit_cnt=SLOT_W-1 the completed
//     slot is written to shadow[slot_cnt]; bit_cnt wraps to 0, slot_cnt increments.
//     Last bit of slot NUM_CH-1: shadow plus the final slot loaded into ch_data,
//     frame_valid=1 on the next cycle; slot_cnt wraps to 0.
//   Frame boundary: first din_en bit after a completed frame must carry sync ->
//     new frame begins, stay RUN. Without sync -> sync_err pulse, bit dropped, go HUNT.
//   Sync mid-frame (any din_en&sync with slot_cnt!=0 or bit_cnt!=0 in RUN) ->
//     sync_err pulse, partial frame discarded, bit taken as new slot0 MSB, stay RUN.
//   Gaps: din_en=0 cycles freeze all state; gaps of any length are legal.
//   Latency: frame_valid and new ch_data visible 1 cycle after last bit's din_en cycle.
//   frame_valid and sync_err never asserted together. ch_data changes only with frame_valid.
//   Counters sized $clog2 of SLOT_W and NUM_CH (min 1 bit); no arithmetic overflow.
// STRUCTURE
//   Shared package: state encoding (ST_HUNT, ST_RUN), default NUM_CH/SLOT_W
//     constants, channel slice helper.
//   Sub-module sipo_shift (SLOT_W-bit serial-in parallel-out, shift enable, sync clear)
//     for slot assembly; counters, FSM and shadow/output regs in tdm_demux.
// TESTING (NUM_CH=4, SLOT_W=8)
//   1 Reset, then sync + bytes A5,3C,0F,F0 back-to-back -> ch_data=F00F3CA5 hex,
//     one frame_valid pulse, locked=1, sync_err never 1.
//   2 Same frame, din_en random ~50% duty -> identical ch_data; frame_valid exactly
//     1 cycle after last qualified bit.
//   3 Frame with sync reasserted at slot2 bit3 -> sync_err pulse, no frame_valid,
//     ch_data keeps previous value; following full frame 11,22,33,44 -> 44332211.
//   4 Complete frame, next bit without sync -> sync_err, locked=0; later
//     sync frame 01,02,03,04 -> locked=1, ch_data=04030201.
//   5 rst_n=0 at slot1 bit4, then full frame 55,AA,55,AA -> outputs 0 during
//     reset, then ch_data=AA55AA55, single frame_valid.
//   6 Bits before first sync in HUNT (32 random) -> no output change, no sync_err.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// -----------------------------------------------------------------------------
// tdm_demux_pkg
//   Shared definitions for the TDM demultiplexer: FSM state encoding, default
//   frame geometry and small helpers for counter sizing and channel slicing.
// -----------------------------------------------------------------------------
package tdm_demux_pkg;

    // Framing FSM: HUNT waits for a sync strobe, RUN tracks slot boundaries.
    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SLOT_W = 8;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of channel ch inside the flattened channel bus.
    function automatic int ch_lsb(input int ch, input int slot_w);
        return ch * slot_w;
    endfunction

endpackage

// File: rtl/tdm_demux_sipo_shift.sv
// -----------------------------------------------------------------------------
// sipo_shift
//   SLOT_W-bit serial-in parallel-out register used to assemble one slot,
//   MSB first. A clear wipes any partial slot; clear together with shift
//   starts a fresh slot whose first bit is din_i.
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   shift_en_i  in   shift din_i in this cycle
//   clear_i     in   discard current contents
//   din_i       in   serial data bit
//   word_o      out  register contents after this cycle's update; on the last
//                    bit of a slot this is the completed slot
// -----------------------------------------------------------------------------
module sipo_shift #(
    parameter int SLOT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en_i,
    input  logic              clear_i,
    input  logic              din_i,
    output logic [SLOT_W-1:0] word_o
);

    logic [SLOT_W-1:0] shift_q;
    logic [SLOT_W-1:0] shift_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        shift_d = shift_q;
        if (shift_en_i) begin
            if (clear_i) begin
                shift_d = {{(SLOT_W-1){1'b0}}, din_i};
            end else begin
                shift_d = {shift_q[SLOT_W-2:0], din_i};
            end
        end else if (clear_i) begin
            shift_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    // The top captures the slot in the same cycle as its last bit, so it
    // needs the post-shift value rather than the registered one.
    assign word_o = shift_d;

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
//   Receive-side time-division demultiplexer. A serial bitstream of NUM_CH
//   slots of SLOT_W bits (MSB first, frame start marked by sync) is assembled
//   slot by slot and presented as a parallel word once per complete frame.
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   din          in   serial data bit
//   din_en       in   qualifies din/sync this cycle; all state frozen when 0
//   sync         in   frame start, marks slot 0 MSB (only with din_en)
//   ch_data      out  channel k at [k*SLOT_W +: SLOT_W]; held between frames
//   frame_valid  out  one-cycle pulse when ch_data takes a new frame
//   sync_err     out  one-cycle pulse on a sync protocol violation
//   locked       out  high while the framer is in RUN
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SLOT_W = DEF_SLOT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din,
    input  logic                     din_en,
    input  logic                     sync,
    output logic [NUM_CH*SLOT_W-1:0] ch_data,
    output logic                     frame_valid,
    output logic                     sync_err,
    output logic                     locked
);

    localparam int BIT_W      = cnt_w(SLOT_W);
    localparam int SLOT_CNT_W = cnt_w(NUM_CH);

    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(SLOT_W - 1);
    localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = SLOT_CNT_W'(NUM_CH - 1);

    state_e                    state_q;
    logic [BIT_W-1:0]          bit_cnt_q;
    logic [SLOT_CNT_W-1:0]     slot_cnt_q;
    // Slots 0..NUM_CH-2 wait here; the last slot goes straight to ch_data.
    logic [SLOT_W-1:0]         shadow_q [NUM_CH-1];
    logic [NUM_CH*SLOT_W-1:0]  ch_data_q;
    logic                      frame_valid_q;
    logic                      sync_err_q;

    logic                      at_boundary;
    logic                      shift_en;
    logic                      sipo_clear;
    logic [SLOT_W-1:0]         slot_word;

    // In RUN both counters are zero only right after a completed frame,
    // because entering a frame always leaves bit_cnt at 1.
    assign at_boundary = (bit_cnt_q == '0) && (slot_cnt_q == '0);

    // Shift whenever the bit is accepted; any accepted sync starts a new slot 0.
    always_comb begin
        shift_en   = 1'b0;
        sipo_clear = 1'b0;
        if (din_en) begin
            if (state_q == ST_HUNT) begin
                shift_en   = sync;
                sipo_clear = sync;
            end else begin
                shift_en   = sync || !at_boundary;
                sipo_clear = sync;
            end
        end
    end

    sipo_shift #(
        .SLOT_W (SLOT_W)
    ) u_sipo (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en),
        .clear_i    (sipo_clear),
        .din_i      (din),
        .word_o     (slot_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            bit_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            ch_data_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            // NOTE: the shadow store is small and must read as zero after
            // reset, so it is reset explicitly rather than left as RAM.
            for (int k = 0; k < NUM_CH - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (din_en) begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (sync) begin
                            state_q    <= ST_RUN;
                            bit_cnt_q  <= BIT_W'(1);
                            slot_cnt_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (sync && !at_boundary) begin
                            // Early sync: drop the partial frame, restart on this bit.
                            sync_err_q <= 1'b1;
                            bit_cnt_q  <= BIT_W'(1);
                            slot_cnt_q <= '0;
                        end else if (!sync && at_boundary) begin
                            // Missing sync after a frame: alignment lost.
                            sync_err_q <= 1'b1;
                            state_q    <= ST_HUNT;
                        end else if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            if (slot_cnt_q == SLOT_LAST) begin
                                slot_cnt_q    <= '0;
                                frame_valid_q <= 1'b1;
                                for (int k = 0; k < NUM_CH - 1; k++) begin
                                    ch_data_q[ch_lsb(k, SLOT_W) +: SLOT_W] <= shadow_q[k];
                                end
                                ch_data_q[ch_lsb(NUM_CH - 1, SLOT_W) +: SLOT_W] <= slot_word;
                            end else begin
                                shadow_q[slot_cnt_q] <= slot_word;
                                slot_cnt_q           <= slot_cnt_q + SLOT_CNT_W'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign ch_data     = ch_data_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == ST_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
//   Self-checking bench for tdm_demux (NUM_CH=4, SLOT_W=8). A bit-queue
//   reference model predicts every output each cycle; directed scenarios add
//   checks against hand-computed frame words.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

    localparam int NUM_CH     = 4;
    localparam int SLOT_W     = 8;
    localparam int FRAME_BITS = NUM_CH * SLOT_W;

    logic                     clk;
    logic                     rst_n;
    logic                     din;
    logic                     din_en;
    logic                     sync;
    logic [NUM_CH*SLOT_W-1:0] ch_data;
    logic                     frame_valid;
    logic                     sync_err;
    logic                     locked;

    tdm_demux #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_en      (din_en),
        .sync        (sync),
        .ch_data     (ch_data),
        .frame_valid (frame_valid),
        .sync_err    (sync_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-scenario event counters, cleared by the directed tests.
    int fv_cnt   = 0;
    int serr_cnt = 0;

    // Reference model: a frame is simply the list of accepted bits since sync.
    bit                       m_locked;
    bit                       m_bits[$];
    logic [NUM_CH*SLOT_W-1:0] m_ch;
    bit                       m_fv;
    bit                       m_se;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit en, input bit d, input bit s);
        if (!rst_n) begin
            m_locked = 0;
            m_bits.delete();
            m_ch = '0;
            m_fv = 0;
            m_se = 0;
            return;
        end
        m_fv = 0;
        m_se = 0;
        if (!en) return;
        if (!m_locked) begin
            if (s) begin
                m_locked = 1;
                m_bits = {d};
            end
        end else if (m_bits.size() == 0) begin
            if (s) m_bits = {d};
            else begin
                m_se = 1;
                m_locked = 0;
            end
        end else if (s) begin
            m_se = 1;
            m_bits = {d};
        end else begin
            m_bits.push_back(d);
        end
        if (m_locked && m_bits.size() == FRAME_BITS) begin
            for (int k = 0; k < NUM_CH; k++)
                for (int b = 0; b < SLOT_W; b++)
                    m_ch[k*SLOT_W + SLOT_W-1-b] = m_bits[k*SLOT_W + b];
            m_fv = 1;
            m_bits.delete();
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare #1 later.
    task automatic cycle(input bit en, input bit d, input bit s);
        din_en = en;
        din    = d;
        sync   = s;
        @(posedge clk);
        model_step(en, d, s);
        #1;
        check("ch_data", ch_data, m_ch);
        check("frame_valid", frame_valid, m_fv);
        check("sync_err", sync_err, m_se);
        check("locked", locked, m_locked);
        fv_cnt   += int'(frame_valid);
        serr_cnt += int'(sync_err);
    endtask

    // Optional idle cycles (with junk on din/sync) before one qualified bit.
    task automatic send_bit(input bit d, input bit s, input int gap_pct);
        while (int'($urandom_range(99)) < gap_pct)
            cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        cycle(1'b1, d, s);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        rst_n = 1'b1;
    endtask

    // w is laid out like ch_data (slot 0 in the low byte). Sync on bit 0 and
    // on bit resync_at; reset instead of sending bit rst_at (-1 = never).
    task automatic send_frame(input logic [NUM_CH*SLOT_W-1:0] w, input int gap_pct,
                              input int resync_at, input int rst_at);
        for (int i = 0; i < FRAME_BITS; i++) begin
            int  sl = i / SLOT_W;
            int  bi = i % SLOT_W;
            bit  d  = w[sl*SLOT_W + SLOT_W-1-bi];
            if (i == rst_at) begin
                do_reset(3);
                return;
            end
            send_bit(d, (i == 0) || (i == resync_at), gap_pct);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        din    = 1'b0;
        din_en = 1'b0;
        sync   = 1'b0;
        m_locked = 0;
        m_ch = '0;
        m_fv = 0;
        m_se = 0;
        do_reset(2);
        check("reset_ch_data", ch_data, 0);
        check("reset_locked", locked, 0);

        // Hunting: unsynced bits are ignored silently.
        fv_cnt = 0; serr_cnt = 0;
        for (int i = 0; i < 32; i++) send_bit(1'($urandom_range(1)), 1'b0, 20);
        check("hunt_ch_data", ch_data, 0);
        check("hunt_serr", serr_cnt, 0);
        check("hunt_locked", locked, 0);

        // Back-to-back frame.
        do_reset(2);
        fv_cnt = 0; serr_cnt = 0;
        send_frame(32'hF00F3CA5, 0, -1, -1);
        check("t1_data", ch_data, 32'hF00F3CA5);
        check("t1_fv_cnt", fv_cnt, 1);
        check("t1_serr", serr_cnt, 0);
        check("t1_locked", locked, 1);

        // Same frame with ~50% qualification duty.
        fv_cnt = 0; serr_cnt = 0;
        send_frame(32'hF00F3CA5, 50, -1, -1);
        check("t2_data", ch_data, 32'hF00F3CA5);
        check("t2_fv_cnt", fv_cnt, 1);
        check("t2_serr", serr_cnt, 0);

        // Sync reasserted at slot2 bit3 aborts the frame.
        fv_cnt = 0; serr_cnt = 0;
        send_frame(32'h99887766, 30, 2*SLOT_W + 3, -1);
        check("t3_serr_cnt", serr_cnt, 1);
        check("t3_fv_cnt", fv_cnt, 0);
        check("t3_hold", ch_data, 32'hF00F3CA5);
        fv_cnt = 0;
        send_frame(32'h44332211, 30, -1, -1);
        check("t3_data", ch_data, 32'h44332211);
        check("t3_fv2_cnt", fv_cnt, 1);

        // Missing sync after a complete frame drops lock.
        send_frame(32'hCAFEBABE, 0, -1, -1);
        serr_cnt = 0;
        send_bit(1'b1, 1'b0, 0);
        check("t4_serr_cnt", serr_cnt, 1);
        check("t4_locked", locked, 0);
        repeat (5) send_bit(1'($urandom_range(1)), 1'b0, 20);
        fv_cnt = 0;
        send_frame(32'h04030201, 20, -1, -1);
        check("t4_locked2", locked, 1);
        check("t4_data", ch_data, 32'h04030201);
        check("t4_fv_cnt", fv_cnt, 1);

        // Reset mid-frame at slot1 bit4.
        send_frame(32'h12345678, 10, -1, SLOT_W + 4);
        check("t5_rst_data", ch_data, 0);
        check("t5_rst_locked", locked, 0);
        fv_cnt = 0; serr_cnt = 0;
        send_frame(32'hAA55AA55, 10, -1, -1);
        check("t5_data", ch_data, 32'hAA55AA55);
        check("t5_fv_cnt", fv_cnt, 1);
        check("t5_serr", serr_cnt, 0);

        // Random frames and random noisy traffic, model-checked each cycle.
        for (int f = 0; f < 6; f++) begin
            int rs;
            rs = ($urandom_range(3) == 0) ? int'($urandom_range(FRAME_BITS-1, 1)) : -1;
            send_frame(32'($urandom), int'($urandom_range(60)), rs, -1);
        end
        for (int i = 0; i < 400; i++)
            send_bit(1'($urandom_range(1)), ($urandom_range(15) == 0), 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
